// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path: active-low digit
// patterns, the scan FSM state type and the invalid-digit code.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0001100;

   localparam logic [3:0] DIGIT_INVALID = 4'hF;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HOLD
   } scan_state_t;

endpackage

// File: rtl/seg2bin.sv
// Combinational decoder from an active-low {a..g} pattern back to a BCD digit;
// anything that is not one of the ten digit glyphs is flagged as an error.
module seg2bin
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       err
);

   always_comb begin
      digit = DIGIT_INVALID;
      err   = 1'b1;
      case (seg)
         SEG_0: begin digit = 4'd0; err = 1'b0; end
         SEG_1: begin digit = 4'd1; err = 1'b0; end
         SEG_2: begin digit = 4'd2; err = 1'b0; end
         SEG_3: begin digit = 4'd3; err = 1'b0; end
         SEG_4: begin digit = 4'd4; err = 1'b0; end
         SEG_5: begin digit = 4'd5; err = 1'b0; end
         SEG_6: begin digit = 4'd6; err = 1'b0; end
         SEG_7: begin digit = 4'd7; err = 1'b0; end
         SEG_8: begin digit = 4'd8; err = 1'b0; end
         SEG_9: begin digit = 4'd9; err = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit BCD value from a multiplexed active-low anode/segment bus,
// publishing a frame only after it has repeated unchanged FRAMES_STABLE times.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE        = 4,
   parameter int FRAMES_STABLE = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] bcd,
   output logic        valid,
   output logic        err,
   output logic [3:0]  digit_err
);

   localparam int CW = $clog2(SETTLE + 1);
   localparam int SW = $clog2(FRAMES_STABLE + 1);
   localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
   localparam logic [SW-1:0] STABLE_C = SW'(FRAMES_STABLE);

   logic [3:0]    an_meta, an_sync;
   logic [6:0]    seg_meta, seg_sync;
   logic          an_onehot;
   logic [1:0]    an_idx;
   logic [3:0]    dec_digit;
   logic          dec_err;

   scan_state_t   state;
   logic [3:0]    cur_an;
   logic [CW-1:0] cnt;
   logic [3:0]    filled;
   logic [15:0]   slot_val;
   logic [3:0]    slot_err;
   logic          frame_done;

   logic [15:0]   prev_frame;
   logic [SW-1:0] stable_cnt, stable_next;
   logic          published;

   // Sync flops reset to the blanked (all-high) bus so the FSM starts in WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         an_meta  <= '1;
         an_sync  <= '1;
         seg_meta <= '1;
         seg_sync <= '1;
      end else begin
         an_meta  <= an;
         an_sync  <= an_meta;
         seg_meta <= seg;
         seg_sync <= seg_meta;
      end
   end

   always_comb begin
      an_onehot = 1'b1;
      an_idx    = 2'd0;
      case (an_sync)
         4'b1110: an_idx = 2'd0;
         4'b1101: an_idx = 2'd1;
         4'b1011: an_idx = 2'd2;
         4'b0111: an_idx = 2'd3;
         default: an_onehot = 1'b0;
      endcase
   end

   seg2bin u_seg2bin (
      .seg   (seg_sync),
      .digit (dec_digit),
      .err   (dec_err)
   );

   assign frame_done = (filled == 4'hF);

   // Scan FSM; also owns the slot registers so the filled mask has one driver
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_WAIT;
         cur_an   <= '1;
         cnt      <= '0;
         filled   <= '0;
         slot_val <= '0;
         slot_err <= '0;
      end else begin
         if (frame_done)
            filled <= '0;
         case (state)
            ST_WAIT: begin
               if (an_onehot) begin
                  state  <= ST_SETTLE;
                  cur_an <= an_sync;
                  cnt    <= CW'(1);
               end
            end
            ST_SETTLE: begin
               if (!an_onehot) begin
                  state <= ST_WAIT;
               end else if (an_sync != cur_an) begin
                  cur_an <= an_sync;
                  cnt    <= CW'(1);
               end else if (cnt == SETTLE_C) begin
                  slot_val[{an_idx, 2'b00} +: 4] <= dec_digit;
                  slot_err[an_idx]               <= dec_err;
                  filled[an_idx]                 <= 1'b1;
                  state                          <= ST_HOLD;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_HOLD: begin
               if (!an_onehot) begin
                  state <= ST_WAIT;
               end else if (an_sync != cur_an) begin
                  state  <= ST_SETTLE;
                  cur_an <= an_sync;
                  cnt    <= CW'(1);
               end
            end
            default: state <= ST_WAIT;
         endcase
      end
   end

   always_comb begin
      stable_next = SW'(1);
      if (slot_val == prev_frame)
         stable_next = (stable_cnt == STABLE_C) ? stable_cnt : stable_cnt + SW'(1);
   end

   // Frame evaluation runs in the cycle after the last slot fills
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd        <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
         digit_err  <= '0;
         prev_frame <= '0;
         stable_cnt <= '0;
         published  <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (frame_done) begin
            digit_err <= slot_err;
            if (|slot_err) begin
               err        <= 1'b1;
               stable_cnt <= '0;
            end else begin
               stable_cnt <= stable_next;
               prev_frame <= slot_val;
               if (stable_next == STABLE_C && (slot_val != bcd || !published)) begin
                  bcd       <= slot_val;
                  valid     <= 1'b1;
                  published <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the 4-digit BCD counter/seven-segment display path: it observes a time-multiplexed, active-low anode/segment bus and recovers the displayed 4-digit BCD value. Each digit's pattern is sampled once its anode has settled, then decoded back to BCD. A complete frame is published only after it repeats identically for a set number of frames. The block serves loopback self-test and board-level display verification.

## Interface
- SETTLE, 4: cycles a one-hot anode must stay unchanged (post-sync) before its segments are sampled; ≥1.
- FRAMES_STABLE, 2: consecutive identical error-free frames required before publishing; ≥1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- an  in  4  anode enables, active-low; an[0] = least-significant digit.
- seg  in  7  cathodes, active-low, {a,b,c,d,e,f,g} with a in bit 6.
- bcd  out  16  published value, 4 BCD nibbles, bcd[3:0] = digit 0.
- valid  out  1  one-cycle pulse when bcd is updated.
- err  out  1  one-cycle pulse at completion of a frame containing an undecodable digit.
- digit_err  out  4  per-digit flag from the most recently completed frame; bit i set if digit i was undecodable.

## Operation
- an and seg pass through a 2-flop synchronizer; all logic below uses the synchronized copies.
- Decode table (seg → digit): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9; any other pattern → 4'hF plus error.
- FSM states:
  - WAIT: anode not one-hot-low (all high = blanking, or multiple low). Go to SETTLE when exactly one bit is low.
  - SETTLE: count cycles with the anode unchanged.
    - Anode changes to a different one-hot value: restart the count for the new digit.
    - Anode becomes non-one-hot: go to WAIT.
    - Count reaches SETTLE: sample seg into the slot for the active digit and mark the slot filled; go to HOLD.
  - HOLD: wait for the anode to change. New one-hot value → SETTLE; non-one-hot → WAIT.
- Resampling a digit already filled in the current frame overwrites its slot.
- Frame completes in the cycle all 4 slots are filled. In the next cycle:
  - clear the slot-filled mask;
  - load digit_err with this frame's error bits.
- Frame with any error:
  - pulse err;
  - clear the stable counter;
  - do not publish.
- Error-free frame:
  - equal to the previous frame: increment the stable counter, saturating at FRAMES_STABLE;
  - otherwise: set the stable counter to 1 and store the frame as the previous frame.
- Publish when the stable counter reaches FRAMES_STABLE and the frame differs from bcd, or when nothing has been published since reset: load bcd and pulse valid.
- A stable value that is unchanged never re-pulses valid.
- Counter widths are $clog2(SETTLE+1) and $clog2(FRAMES_STABLE+1); no wrap-around is possible.

## Timing
- Reset values: bcd=16'h0000, valid=0, err=0, digit_err=4'b0000. FSM=WAIT, slots empty, stable counter=0, published flag=0.
- rst asserted mid-frame discards partial slots; the first sample after release needs a fresh full settle.
- Input-to-sample latency: 2 sync cycles + SETTLE cycles from an input anode change to the slot write.
- valid/err rise 1 cycle after the slot-filling sample that completes the frame; each is high for exactly 1 cycle.
- valid and err are never asserted in the same cycle.
- Minimum dwell per digit to be captured: SETTLE+1 cycles at the input.

## Structure
- Package seg_pkg holds:
  - the ten 7-bit active-low digit pattern constants (shared with the display encoder);
  - the FSM state typedef (WAIT/SETTLE/HOLD);
  - the invalid-digit code 4'hF.
- One sub-module, seg2bin: combinational 7-bit pattern → {err, 4-bit digit} decoder, one instance muxed by the active anode.
- The top level holds the synchronizer, FSM, slot registers, frame comparator and publish logic.

## Test plan
- Scan "1234" cyclically, 8 cycles per digit, after rst → bcd=16'h1234 with a single valid pulse at the end of the 2nd frame; no further pulses while the scan continues.
- Stable "0099", then switch to "0100" → second valid pulse 2 frames after the change; bcd=16'h0100.
- Digit 2 driven 1111111 (blank pattern) while "5678" is displayed → err pulses every frame, digit_err=4'b0100, bcd unchanged, valid never asserted.
- Anode held for only SETTLE-1 cycles per digit → no samples, no valid/err, FSM alternates SETTLE.
- All-high blanking gaps of 3 cycles between digits of "9876" → value still captured; bcd=16'h9876.
- rst pulsed after 3 of 4 digits of a frame → all outputs 0; the next two full frames publish correctly.
